// File: rtl/uart_rx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_if : serial-line and receive-result bundle for uart_rx.          |
// | Optional parity_err member exists when UART_RX_PARITY_EN is defined.     |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            busy;
`ifdef UART_RX_PARITY_EN
  logic            parity_err;

  modport master (
    output rx, s_tick,
    input  dout, rx_done_tick, frame_err, busy, parity_err
  );

  modport slave (
    input  rx, s_tick,
    output dout, rx_done_tick, frame_err, busy, parity_err
  );
`else
  modport master (
    output rx, s_tick,
    input  dout, rx_done_tick, frame_err, busy
  );

  modport slave (
    input  rx, s_tick,
    output dout, rx_done_tick, frame_err, busy
  );
`endif
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx : 16x-oversampled UART receiver, mid-bit sampling, LSB first,    |
// | one-clk done/frame-error strobes. Define UART_RX_PARITY_EN for an even   |
// | parity bit between data and stop, reported on parity_err.                |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_start  = 3'd1;
  localparam logic [2:0] c_st_data   = 3'd2;
  localparam logic [2:0] c_st_stop   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] c_st_parity = 3'd4;
`endif

  localparam logic [4:0] c_mid_start = 5'd7;
  localparam logic [4:0] c_bit_end   = 5'd15;
  localparam logic [4:0] c_stop_end  = 5'(SB_TICK - 1);
  localparam logic [2:0] c_last_bit  = 3'(DBIT - 1);

  logic            r_rx_meta;
  logic            r_rx_s;
  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic [4:0]      r_s;
  logic [4:0]      w_s_nxt;
  logic [2:0]      r_n;
  logic [2:0]      w_n_nxt;
  logic [DBIT-1:0] r_sr;
  logic [DBIT-1:0] w_sr_nxt;
  logic [DBIT-1:0] r_dout;
  logic            r_done;
  logic            r_ferr;
  logic            w_frame_end;
  logic            w_ferr_nxt;
  logic            w_busy;
`ifdef UART_RX_PARITY_EN
  logic            r_par;
  logic            w_par_nxt;
  logic            r_perr;
  logic            w_perr_nxt;
`endif

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // State register together with counters, shifter and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
      r_s     <= '0;
      r_n     <= '0;
      r_sr    <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_sr    <= w_sr_nxt;
      r_done  <= w_frame_end;
      r_ferr  <= w_ferr_nxt;
      if (w_frame_end) begin
        r_dout <= r_sr;
      end
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_nxt;
      r_perr  <= w_perr_nxt;
`endif
    end
  end

  // Next-state logic; counters only advance on s_tick.
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_sr_nxt    = r_sr;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      c_st_idle: begin
        if (!r_rx_s) begin
          w_state_nxt = c_st_start;
          w_s_nxt     = '0;
        end
      end
      c_st_start: begin
        if (bus.s_tick) begin
          if (r_s == c_mid_start) begin
            if (!r_rx_s) begin
              w_state_nxt = c_st_data;
              w_s_nxt     = '0;
              w_n_nxt     = '0;
            end else begin
              w_state_nxt = c_st_idle;
            end
          end else begin
            w_s_nxt = r_s + 5'd1;
          end
        end
      end
      c_st_data: begin
        if (bus.s_tick) begin
          if (r_s == c_bit_end) begin
            w_sr_nxt = {r_rx_s, r_sr[DBIT-1:1]};
            w_s_nxt  = '0;
            if (r_n == c_last_bit) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = c_st_parity;
`else
              w_state_nxt = c_st_stop;
`endif
            end else begin
              w_n_nxt = r_n + 3'd1;
            end
          end else begin
            w_s_nxt = r_s + 5'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      c_st_parity: begin
        if (bus.s_tick) begin
          if (r_s == c_bit_end) begin
            w_par_nxt   = r_rx_s;
            w_s_nxt     = '0;
            w_state_nxt = c_st_stop;
          end else begin
            w_s_nxt = r_s + 5'd1;
          end
        end
      end
`endif
      c_st_stop: begin
        if (bus.s_tick) begin
          if (r_s == c_stop_end) begin
            w_state_nxt = c_st_idle;
          end else begin
            w_s_nxt = r_s + 5'd1;
          end
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // Output decode: strobes are registered from these one cycle later.
  always_comb begin
    w_frame_end = (r_state == c_st_stop) && bus.s_tick && (r_s == c_stop_end);
    w_ferr_nxt  = w_frame_end && !r_rx_s;
    w_busy      = (r_state != c_st_idle);
`ifdef UART_RX_PARITY_EN
    w_perr_nxt  = w_frame_end && ((^r_sr) ^ r_par);
`endif
  end

  assign bus.dout         = r_dout;
  assign bus.rx_done_tick = r_done;
  assign bus.frame_err    = r_ferr;
  assign bus.busy         = w_busy;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = r_perr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx : directed frames against a frame-level scoreboard of uart_rx |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module tb_uart_rx;

  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  uart_rx_if #(.DBIT(DBIT)) u_if ();

  uart_rx #(
    .DBIT    (DBIT),
    .SB_TICK (SB_TICK)
  ) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         n_done = 0;
  int         n_ferr = 0;
  exp_t       q[$];
  exp_t       e;
  logic [7:0] model_dout = 8'h00;
  logic       prev_busy  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // s_tick: one clk high out of every four.
  initial begin
    u_if.s_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 u_if.s_tick = 1'b1;
      @(posedge clk);
      #1 u_if.s_tick = 1'b0;
    end
  end

  // Returns 1 time unit after the next clk edge that carried an s_tick.
  task automatic wait_tick();
    @(posedge clk);
    while (u_if.s_tick !== 1'b1) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int nticks);
    u_if.rx = b;
    repeat (nticks) wait_tick();
  endtask

  // Whole frame; a bad stop bit is held low for 12 ticks then high for 4.
  task automatic send_frame(input logic [7:0] data, input logic stop_ok, input logic par);
    exp_t x;
    x.data = data;
    x.ferr = !stop_ok;
    x.perr = (^data) ^ par;
    q.push_back(x);
    send_bit(1'b0, 16);
    for (int i = 0; i < DBIT; i++) send_bit(data[i], 16);
`ifdef UART_RX_PARITY_EN
    send_bit(par, 16);
`endif
    if (stop_ok) begin
      send_bit(1'b1, 16);
    end else begin
      send_bit(1'b0, 12);
      send_bit(1'b1, 4);
    end
  endtask

  // Frame-level scoreboard: strobes must match queued frames, dout must hold otherwise.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      check("reset_dout", 32'(u_if.dout), 32'h0);
      check("reset_done", 32'(u_if.rx_done_tick), 32'h0);
      check("reset_ferr", 32'(u_if.frame_err), 32'h0);
      check("reset_busy", 32'(u_if.busy), 32'h0);
`ifdef UART_RX_PARITY_EN
      check("reset_perr", 32'(u_if.parity_err), 32'h0);
`endif
      model_dout = 8'h00;
      prev_busy  = 1'b0;
    end else begin
      if (u_if.rx_done_tick === 1'b1) begin
        n_done++;
        if (q.size() == 0) begin
          check("unexpected_done", 32'h1, 32'h0);
        end else begin
          e = q.pop_front();
          check("done_dout", 32'(u_if.dout), 32'(e.data));
          check("done_ferr", 32'(u_if.frame_err), 32'(e.ferr));
`ifdef UART_RX_PARITY_EN
          check("done_perr", 32'(u_if.parity_err), 32'(e.perr));
`endif
          check("busy_at_done", 32'(u_if.busy), 32'h0);
          check("busy_before_done", 32'(prev_busy), 32'h1);
          model_dout = e.data;
          if (e.ferr) n_ferr++;
        end
      end else begin
        check("done_level", 32'(u_if.rx_done_tick), 32'h0);
        check("ferr_without_done", 32'(u_if.frame_err), 32'h0);
        check("dout_hold", 32'(u_if.dout), 32'(model_dout));
`ifdef UART_RX_PARITY_EN
        check("perr_without_done", 32'(u_if.parity_err), 32'h0);
`endif
      end
      prev_busy = u_if.busy;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    u_if.rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_tick();
    send_bit(1'b1, 4);

    // Clean frame.
    send_frame(8'hA5, 1'b1, 1'b0);
    send_bit(1'b1, 8);
    check("drain_a5", 32'(q.size()), 32'h0);
    check("lit_dout_a5", 32'(u_if.dout), 32'hA5);
    check("lit_busy_idle", 32'(u_if.busy), 32'h0);

    // Stop bit sampled low.
    send_frame(8'h3C, 1'b0, 1'b0);
    send_bit(1'b1, 8);
    check("drain_3c", 32'(q.size()), 32'h0);
    check("lit_dout_3c", 32'(u_if.dout), 32'h3C);
    check("lit_busy_after_3c", 32'(u_if.busy), 32'h0);

    // Start glitch of 4 ticks, then a real frame.
    send_bit(1'b0, 4);
    send_bit(1'b1, 2);
    check("lit_busy_glitch", 32'(u_if.busy), 32'h1);
    send_bit(1'b1, 10);
    check("lit_busy_after_glitch", 32'(u_if.busy), 32'h0);
    check("lit_dout_glitch_hold", 32'(u_if.dout), 32'h3C);
    send_frame(8'h81, 1'b1, 1'b0);
    send_bit(1'b1, 8);
    check("drain_81", 32'(q.size()), 32'h0);
    check("lit_dout_81", 32'(u_if.dout), 32'h81);

    // Back-to-back with no idle gap.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_bit(1'b1, 8);
    check("drain_b2b", 32'(q.size()), 32'h0);
    check("lit_dout_ff", 32'(u_if.dout), 32'hFF);

    // Reset during the 4th data bit of 0x55.
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b0, 6);
    check("lit_busy_mid_frame", 32'(u_if.busy), 32'h1);
    rst_n   = 1'b0;
    u_if.rx = 1'b1;
    #2;
    check("lit_reset_dout", 32'(u_if.dout), 32'h0);
    check("lit_reset_busy", 32'(u_if.busy), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_tick();
    send_bit(1'b1, 8);
    send_frame(8'hC3, 1'b1, 1'b0);
    send_bit(1'b1, 8);
    check("drain_c3", 32'(q.size()), 32'h0);
    check("lit_dout_c3", 32'(u_if.dout), 32'hC3);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h5A, 1'b1, 1'b0);
    send_bit(1'b1, 8);
    check("lit_dout_5a", 32'(u_if.dout), 32'h5A);
    send_frame(8'h5B, 1'b1, 1'b0);
    send_bit(1'b1, 8);
    check("drain_parity", 32'(q.size()), 32'h0);
    check("lit_dout_5b", 32'(u_if.dout), 32'h5B);
    check("lit_done_count", 32'(n_done), 32'd8);
`else
    check("lit_done_count", 32'(n_done), 32'd6);
`endif
    check("lit_ferr_count", 32'(n_ferr), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
